// File: rtl/ddr3_bus_adapter.sv
// ddr3_bus_adapter: one-at-a-time bridge from a 128-bit request/response port to the DDR3 controller user interface, with read-modify-write for byte-masked writes
module ddr3_bus_adapter #(
    parameter int ADDR_WIDTH = 30
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [15:0]           cmd_mask_i,
    input  logic [127:0]          cmd_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_write_o,
    output logic [127:0]          rsp_data_o,
    output logic                  rd_addr_en_o,
    output logic [31:0]           rd_addr_o,
    output logic                  rd_en_o,
    input  logic                  rd_valid_i,
    input  logic [127:0]          rd_data_i,
    input  logic                  rd_busy_i,
    output logic                  wr_en_o,
    output logic [31:0]           wr_addr_o,
    output logic [127:0]          wr_data_o,
    output logic                  wr_addr_en_o,
    output logic [15:0]           wr_datamask_o,
    input  logic                  wr_ack_i,
    input  logic                  wr_busy_i
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] MERGE   = 3'd3;
    localparam logic [2:0] WR_REQ  = 3'd4;
    localparam logic [2:0] WR_WAIT = 3'd5;
    localparam logic [2:0] RSP     = 3'd6;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-5:0] addr_q, addr_d;
    logic [15:0]           mask_q, mask_d;
    logic [127:0]          data_q, data_d, rdata_q, rdata_d, wr_data_q, wr_data_d, merged;
    logic                  write_q, write_d, rd_addr_en_q, rd_addr_en_d, rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic                  want_rd, want_wr;
    logic [31:0]           rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic                  unused_low_addr;

    // Byte offset within the 16-byte word has no meaning to the controller
    assign unused_low_addr = ^cmd_addr_i[3:0];

    assign cmd_ready_o   = reset_n && state_q == IDLE;
    assign rsp_valid_o   = state_q == RSP;
    assign rsp_write_o   = rsp_valid_o && write_q;
    assign rsp_data_o    = (rsp_valid_o && !write_q) ? rdata_q : '0;
    assign rd_addr_en_o  = rd_addr_en_q;
    assign rd_addr_o     = rd_addr_q;
    assign rd_en_o       = rd_en_q;
    assign wr_en_o       = wr_en_q;
    assign wr_addr_en_o  = wr_en_q;
    assign wr_addr_o     = wr_addr_q;
    assign wr_data_o     = wr_data_q;
    assign wr_datamask_o = '1;

    // Overlay enabled write bytes on the word read back from memory
    always_comb begin
        for (int i = 0; i < 16; i++) merged[8*i +: 8] = mask_q[i] ? data_q[8*i +: 8] : rdata_q[8*i +: 8];
    end

    // Sequence one transaction; a read or write is issued straight away whenever the controller is not busy
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        mask_d       = mask_q;
        data_d       = data_q;
        write_d      = write_q;
        rdata_d      = rdata_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rd_addr_en_d = 1'b0;
        wr_en_d      = 1'b0;
        want_rd      = 1'b0;
        want_wr      = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid_i) begin
                addr_d  = cmd_addr_i[ADDR_WIDTH-1:4];
                mask_d  = cmd_mask_i;
                data_d  = cmd_data_i;
                write_d = cmd_write_i;
                if (!cmd_write_i || (|cmd_mask_i && !(&cmd_mask_i))) want_rd = 1'b1;
                else if (&cmd_mask_i) want_wr = 1'b1;
                else state_d = RSP;
            end
            RD_REQ:  want_rd = 1'b1;
            RD_WAIT: if (rd_valid_i) begin
                rdata_d = rd_data_i;
                state_d = write_q ? MERGE : RSP;
            end
            MERGE: begin
                data_d  = merged;
                want_wr = 1'b1;
            end
            WR_REQ:  want_wr = 1'b1;
            WR_WAIT: if (wr_ack_i) state_d = RSP;
            RSP:     if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (want_rd) begin
            state_d      = rd_busy_i ? RD_REQ : RD_WAIT;
            rd_addr_en_d = !rd_busy_i;
            rd_addr_d    = rd_busy_i ? rd_addr_q : 32'(addr_d);
        end
        if (want_wr) begin
            state_d   = wr_busy_i ? WR_REQ : WR_WAIT;
            wr_en_d   = !wr_busy_i;
            wr_addr_d = wr_busy_i ? wr_addr_q : 32'(addr_d);
            wr_data_d = wr_busy_i ? wr_data_q : data_d;
        end
        rd_en_d = state_d == RD_WAIT;
    end

    // Transaction state and registered controller-side outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            mask_q       <= '0;
            data_q       <= '0;
            write_q      <= 1'b0;
            rdata_q      <= '0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_addr_en_q <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            mask_q       <= mask_d;
            data_q       <= data_d;
            write_q      <= write_d;
            rdata_q      <= rdata_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_addr_en_q <= rd_addr_en_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
        end
    end
endmodule

// File: doc/ddr3_bus_adapter.md
# ddr3_bus_adapter

Bridges the SoC's 128-bit request/response memory port onto the DDR3 controller user interface (`rd_addr_en`/`rd_en`/`rd_valid`, `wr_en`/`wr_ack`). Handles one transaction at a time. Translates byte addresses to 16-byte word addresses. Implements partial (byte-masked) writes as read-modify-write, because the controller's `wr_datamask` is not used. The adapter sits directly upstream of the controller and shares its clock and reset.

## Interface
- `ADDR_WIDTH`, default 30: width of the upstream byte address.
- `clk`  in  1  system clock, same as the controller's `clk`.
- `reset_n`  in  1  reset, synchronous, active-low. Clock is `clk`.
- `cmd_valid`  in  1  upstream request valid.
- `cmd_ready`  out  1  request accepted when `cmd_valid & cmd_ready`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  byte address. Bits [3:0] are ignored.
- `cmd_mask`  in  16  byte enables for writes (bit i = byte i = `data[8i+7:8i]`).
- `cmd_data`  in  128  write data.
- `rsp_valid`  out  1  response valid. Held until `rsp_ready`.
- `rsp_ready`  in  1  upstream accepts the response.
- `rsp_write`  out  1  response belongs to a write.
- `rsp_data`  out  128  read data. 0 for write responses.
- Controller side: `rd_addr_en`, `rd_addr[31:0]`, `rd_en` (out); `rd_valid`, `rd_data[127:0]`, `rd_busy` (in); `wr_en`, `wr_addr[31:0]`, `wr_data[127:0]`, `wr_addr_en`, `wr_datamask[15:0]` (out); `wr_ack`, `wr_busy` (in).

## Operation
- Word address: `waddr = {zero-extend, cmd_addr[ADDR_WIDTH-1:4]}`. It is driven on both `rd_addr` and `wr_addr`.
- `wr_datamask` is tied to 16'hFFFF. `wr_addr_en` is asserted together with `wr_en`.
- Accepted requests are latched into `addr_q`, `mask_q`, `data_q`, `write_q`.
- FSM states: IDLE, RD_REQ, RD_WAIT, MERGE, WR_REQ, WR_WAIT, RSP.
- IDLE: `cmd_ready=1`. On accept:
  - read → RD_REQ.
  - write with mask 16'hFFFF → WR_REQ.
  - write with mask 0 → RSP (no memory access).
  - other write → RD_REQ (RMW).
- RD_REQ: if `!rd_busy`, pulse `rd_addr_en` for one cycle and go to RD_WAIT. Otherwise stay.
- RD_WAIT: `rd_en=1`. On `rd_valid` (pop happens that cycle), capture `rd_data`.
  - Read transaction → RSP with `rsp_data` = captured data.
  - RMW → MERGE.
- MERGE (1 cycle): `data_q[8i+7:8i]` = `mask_q[i]` ? `data_q` byte : read byte, for each byte. Then → WR_REQ.
- WR_REQ: if `!wr_busy`, pulse `wr_en` for one cycle with `data_q` and go to WR_WAIT. Otherwise stay.
- WR_WAIT: wait for the `wr_ack` pulse, then → RSP with `rsp_write=1`, `rsp_data=0`.
- RSP: `rsp_valid=1`. On `rsp_ready` → IDLE.
- `cmd_ready` is 0 outside IDLE. Exactly one controller operation of each kind is in flight at most.
- `rd_valid` or `wr_ack` seen outside RD_WAIT / WR_WAIT is ignored. The bench flags this as a protocol error.

## Timing
- Reset values: `cmd_ready=0` in the reset cycle, then 1 (IDLE). `rsp_valid=0`, `rsp_write=0`, `rsp_data=0`, `rd_addr_en=0`, `rd_en=0`, `wr_en=0`, `wr_addr_en=0`. `rd_addr`, `wr_addr` and `wr_data` are 0.
- All controller-side outputs are registered.
  - `rd_addr_en` and `wr_en` are high for exactly one cycle per operation.
  - Address and data are stable from that cycle until the next operation.
- Read latency: accept at cycle N.
  - `rd_addr_en` is high in cycle N+1 when not busy.
  - Response `rsp_valid` rises the cycle after `rd_valid & rd_en`.
- Full write: `wr_en` is high in cycle N+1. `rsp_valid` rises the cycle after `wr_ack`.
- RMW adds read latency + 1 MERGE cycle before `wr_en`.
- Zero-mask write: `rsp_valid` is high in cycle N+1.
- Back-to-back: the next request can be accepted in the cycle after `rsp_valid & rsp_ready`.
- Reset mid-operation: FSM returns to IDLE and all outputs take reset values. The in-flight transaction is dropped without response. The controller is reset by the same `reset_n`.

## Test plan
- Full write then read: write addr 0x100, mask FFFF, data 0x0123…EF → one `wr_en` with `wr_addr=0x10`, write response. Read 0x100 → `rd_addr=0x10`, `rsp_data` equals the written data.
- Partial write (RMW): word 0x20 preloaded with all 0xAA. Write mask 16'h000F, data all 0x55 → one read, then one write. Readback gives bytes 0–3 = 0x55 and bytes 4–15 = 0xAA.
- Zero mask: write with mask 0 → response in cycle N+1, no `rd_addr_en` or `wr_en` ever asserted.
- Busy stall: hold `rd_busy=1` for 10 cycles during a read → `rd_addr_en` is first asserted the cycle after busy drops. The same check applies to `wr_busy` with `wr_en`.
- Response backpressure: `rsp_ready=0` for 5 cycles → `rsp_valid` and `rsp_data` are held stable and `cmd_ready` stays 0. The next command is accepted right after the handshake.
- Reset during RD_WAIT: deassert `reset_n` for 1 cycle → all outputs take reset values, no response is issued, and a subsequent read completes normally.
